// File: rtl/pipe_generator.sv
// Source end of the scrolling pipe chain: emits empty columns, then pipe columns
// with an LFSR-chosen gap, advancing on a self-generated move tick.
module pipe_generator #(
    parameter int         ROWS       = 15,
    parameter int         GAP_SIZE   = 4,
    parameter int         GAP_BITS   = 4,
    parameter int         SPACING    = 6,
    parameter int         PIPE_WIDTH = 2,
    parameter int         MOVE_DIV   = 176,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            gameOver,
    output logic [ROWS-1:0] newPipe,
    output logic            move
);

    localparam int TICK_W  = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int CNT_MAX = (SPACING > PIPE_WIDTH) ? SPACING : PIPE_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int GL_W    = $clog2(ROWS + 1);
    localparam int N_SLOTS = ROWS - GAP_SIZE - 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(MOVE_DIV - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(SPACING - 1);
    localparam logic [CNT_W-1:0]  PIPE_LAST = CNT_W'(PIPE_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_GAP  = 1'b0,
        ST_PIPE = 1'b1
    } state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Raw values past the last legal slot fold back to the bottom of the range.
    function automatic logic [GL_W-1:0] gap_lo_of(input logic [7:0] l);
        logic [GAP_BITS-1:0] raw;
        int                  idx;
        raw = l[GAP_BITS-1:0];
        if (int'(raw) >= N_SLOTS) begin
            idx = int'(raw) - N_SLOTS;
        end else begin
            idx = int'(raw);
        end
        return GL_W'(idx + 1);
    endfunction

    function automatic logic [ROWS-1:0] pipe_pattern(input logic [GL_W-1:0] lo);
        logic [ROWS-1:0] p;
        p = '1;
        for (int i = 0; i < ROWS; i++) begin
            if ((i >= int'(lo)) && (i < int'(lo) + GAP_SIZE)) begin
                p[i] = 1'b0;
            end else begin
                p[i] = 1'b1;
            end
        end
        return p;
    endfunction

    logic [TICK_W-1:0] tick_q, tick_d;
    logic              move_q, move_d;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GL_W-1:0]   gap_lo_q, gap_lo_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [ROWS-1:0]   pipe_q, pipe_d;
    logic              step_s;

    assign step_s  = move_q & ~gameOver;
    assign newPipe = pipe_q;
    assign move    = move_q;

    // Free-running move divider; keeps running while the game is over.
    always_comb begin
        tick_d = tick_q;
        move_d = 1'b0;
        if (tick_q == TICK_LAST) begin
            tick_d = '0;
            move_d = 1'b1;
        end else begin
            tick_d = tick_q + TICK_W'(1);
            move_d = 1'b0;
        end
    end

    // Column sequencer: only advances on an accepted move.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_lo_d = gap_lo_q;
        lfsr_d   = lfsr_q;
        pipe_d   = pipe_q;
        if (step_s) begin
            case (state_q)
                ST_GAP: begin
                    pipe_d = '0;
                    if (cnt_q == GAP_LAST) begin
                        state_d  = ST_PIPE;
                        cnt_d    = '0;
                        gap_lo_d = gap_lo_of(lfsr_q);
                        lfsr_d   = lfsr_next(lfsr_q);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_PIPE: begin
                    pipe_d = pipe_pattern(gap_lo_q);
                    if (cnt_q == PIPE_LAST) begin
                        state_d = ST_GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    pipe_d  = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q   <= '0;
            move_q   <= 1'b0;
            state_q  <= ST_GAP;
            cnt_q    <= '0;
            gap_lo_q <= GL_W'(1);
            lfsr_q   <= LFSR_SEED;
            pipe_q   <= '0;
        end else begin
            tick_q   <= tick_d;
            move_q   <= move_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gap_lo_q <= gap_lo_d;
            lfsr_q   <= lfsr_d;
            pipe_q   <= pipe_d;
        end
    end

endmodule

// File: tb/tb_pipe_generator.sv
// Directed and soak bench for pipe_generator with a short move period.
module tb_pipe_generator;

    logic        clk;
    logic        reset;
    logic        gameOver;
    logic [14:0] newPipe;
    logic        move;

    int total = 0;
    int bad   = 0;

    pipe_generator #(.MOVE_DIV(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .gameOver (gameOver),
        .newPipe  (newPipe),
        .move     (move)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next move pulse, then for the edge that consumes it.
    task automatic do_move();
        int n;
        n = 0;
        while (move !== 1'b1 && n < 32) begin
            @(negedge clk);
            n++;
        end
        check_value("move_seen", {31'd0, move}, 32'd1);
        @(negedge clk);
        check_value("move_width", {31'd0, move}, 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_value("rst_newpipe", {17'd0, newPipe}, 32'd0);
        check_value("rst_move", {31'd0, move}, 32'd0);
        reset = 1'b1;
    endtask

    function automatic logic [14:0] tb_pattern(input int gl);
        logic [14:0] p;
        p = 15'h7FFF;
        for (int i = 0; i < 4; i++) p[gl + i] = 1'b0;
        return p;
    endfunction

    function automatic int tb_gap(input logic [7:0] l);
        int raw;
        raw = int'(l[3:0]);
        if (raw >= 10) raw = raw - 10;
        return raw + 1;
    endfunction

    logic [14:0] exp_seq [16] = '{
        15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h7C3F, 15'h7C3F,
        15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h7FE1, 15'h7FE1
    };

    initial begin
        logic [7:0]  m_lfsr;
        logic [14:0] prev_out;
        int          zero_run;
        int          pipe_run;
        int          gl;
        int          zeros;
        bit          frozen;

        reset    = 1'b0;
        gameOver = 1'b0;

        // Move pulse timing after reset release
        apply_reset();
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            check_value($sformatf("move_tick_%0d", k), {31'd0, move}, (k % 8 == 0) ? 32'd1 : 32'd0);
        end

        // Basic sequence from reset
        apply_reset();
        for (int k = 0; k < 16; k++) begin
            do_move();
            check_value($sformatf("seq_move_%0d", k + 1), {17'd0, newPipe}, {17'd0, exp_seq[k]});
        end

        // Freeze right after move 7
        apply_reset();
        for (int k = 0; k < 7; k++) do_move();
        check_value("frz_pre", {17'd0, newPipe}, 32'h7C3F);
        gameOver = 1'b1;
        for (int k = 0; k < 20; k++) begin
            do_move();
            check_value($sformatf("frz_hold_%0d", k), {17'd0, newPipe}, 32'h7C3F);
        end
        gameOver = 1'b0;
        do_move();
        check_value("frz_move8", {17'd0, newPipe}, 32'h7C3F);
        do_move();
        check_value("frz_move9", {17'd0, newPipe}, 32'h0);

        // Asynchronous reset while in the pipe state
        apply_reset();
        for (int k = 0; k < 7; k++) do_move();
        check_value("arst_pre", {17'd0, newPipe}, 32'h7C3F);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_value("arst_newpipe", {17'd0, newPipe}, 32'h0);
        check_value("arst_move", {31'd0, move}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            do_move();
            check_value($sformatf("arst_move_%0d", k), {17'd0, newPipe}, (k == 7) ? 32'h7C3F : 32'h0);
        end

        // Random freeze soak with structural and gap-model checks
        apply_reset();
        m_lfsr   = 8'hA5;
        prev_out = 15'h0;
        zero_run = 0;
        pipe_run = 0;
        for (int it = 0; it < 1000; it++) begin
            gameOver = ($urandom_range(0, 3) == 0);
            frozen   = gameOver;
            do_move();
            if (frozen) begin
                check_value("soak_freeze", {17'd0, newPipe}, {17'd0, prev_out});
            end else if (newPipe == 15'h0) begin
                if (pipe_run > 0) begin
                    check_value("soak_pipe_width", pipe_run, 2);
                    pipe_run = 0;
                end
                zero_run++;
            end else if (pipe_run == 0) begin
                check_value("soak_spacing", zero_run, 6);
                zero_run = 0;
                gl    = 0;
                zeros = 0;
                for (int i = 14; i >= 0; i--) begin
                    if (!newPipe[i]) begin
                        gl = i;
                        zeros++;
                    end
                end
                check_value("soak_zeros", zeros, 4);
                check_value("soak_edges", {30'd0, newPipe[14], newPipe[0]}, 32'd3);
                check_value("soak_gap_range", (gl >= 1 && gl <= 10) ? 32'd1 : 32'd0, 32'd1);
                check_value("soak_contig", {17'd0, newPipe}, {17'd0, tb_pattern(gl)});
                check_value("soak_gap_model", gl, tb_gap(m_lfsr));
                m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
                pipe_run = 1;
            end else begin
                check_value("soak_same_col", {17'd0, newPipe}, {17'd0, prev_out});
                pipe_run++;
            end
            prev_out = newPipe;
        end
        gameOver = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
